// File: rtl/par2ser_pkg.sv
// +----------------------------------------------------------------------------+
// | ser_link_pkg : types and helpers shared by the par2ser / ser2par link      |
// | Revision     : 1.0 - initial release                                       |
// +----------------------------------------------------------------------------+
`default_nettype none

package ser_link_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } p2s_state_e;

  // Bit-counter width for a W-bit frame; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/par2ser_if.sv
// +----------------------------------------------------------------------------+
// | par2ser_if : word handshake in, serial lane out                            |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

interface par2ser_if #(
  parameter int W = 8
);
  logic [W-1:0] par_din;
  logic         par_din_valid;
  logic         par_din_ready;
  logic         ser_dout;
  logic         ser_dout_valid;
  logic         ser_dout_last;

  modport master (
    output par_din, par_din_valid,
    input  par_din_ready, ser_dout, ser_dout_valid, ser_dout_last
  );

  modport slave (
    input  par_din, par_din_valid,
    output par_din_ready, ser_dout, ser_dout_valid, ser_dout_last
  );
endinterface

`default_nettype wire

// File: rtl/par2ser.sv
// +----------------------------------------------------------------------------+
// | par2ser : parallel-to-serial transmitter, MSB first, one-word hold buffer  |
// |           Optional even parity bit per frame with PAR2SER_PARITY_EN.       |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module par2ser
  import ser_link_pkg::*;
#(
  parameter int W = 8
) (
  input  logic     clk,
  input  logic     rst,
  par2ser_if.slave bus
);

  localparam int            CW       = cnt_width(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  p2s_state_e    state, state_n;
  logic [W-1:0]  sreg, sreg_n;
  logic [W-1:0]  hold_q, hold_q_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          hold_full, hold_full_n;
  logic          accept;
  logic          frame_end;
  logic          load_en;
  logic [W-1:0]  load_word;
`ifdef PAR2SER_PARITY_EN
  logic          par_q, par_q_n;
`endif

  // ready comes only from hold_full, so accept never loops back through valid
  assign accept = bus.par_din_valid && !hold_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sreg      <= '0;
      hold_q    <= '0;
      cnt       <= '0;
      hold_full <= 1'b0;
`ifdef PAR2SER_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      sreg      <= sreg_n;
      hold_q    <= hold_q_n;
      cnt       <= cnt_n;
      hold_full <= hold_full_n;
`ifdef PAR2SER_PARITY_EN
      par_q     <= par_q_n;
`endif
    end
  end

  always_comb begin
    state_n     = state;
    sreg_n      = sreg;
    hold_q_n    = hold_q;
    cnt_n       = cnt;
    hold_full_n = hold_full;
    frame_end   = 1'b0;
    load_en     = 1'b0;
    load_word   = bus.par_din;
`ifdef PAR2SER_PARITY_EN
    par_q_n     = par_q;
`endif

    case (state)
      IDLE: begin
        if (accept) begin
          load_en = 1'b1;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        sreg_n = {sreg[W-2:0], 1'b0};
        cnt_n  = cnt + 1'b1;
        if (cnt == CNT_LAST) begin
`ifdef PAR2SER_PARITY_EN
          // parity bit rides in the MSB so ser_dout stays sreg[W-1]
          sreg_n[W-1] = par_q;
          cnt_n       = '0;
          state_n     = PARITY;
          if (accept) begin
            hold_q_n    = bus.par_din;
            hold_full_n = 1'b1;
          end
`else
          frame_end = 1'b1;
`endif
        end else if (accept) begin
          hold_q_n    = bus.par_din;
          hold_full_n = 1'b1;
        end
      end
`ifdef PAR2SER_PARITY_EN
      PARITY: frame_end = 1'b1;
`endif
      default: state_n = IDLE;
    endcase

    // Hold register has priority; it is never full while a new word is accepted.
    if (frame_end) begin
      cnt_n = '0;
      if (hold_full) begin
        load_en     = 1'b1;
        load_word   = hold_q;
        hold_full_n = 1'b0;
        state_n     = SHIFT;
      end else if (accept) begin
        load_en = 1'b1;
        state_n = SHIFT;
      end else begin
        state_n = IDLE;
      end
    end

    if (load_en) begin
      sreg_n  = load_word;
      cnt_n   = '0;
`ifdef PAR2SER_PARITY_EN
      par_q_n = ^load_word;
`endif
    end
  end

  assign bus.par_din_ready  = !hold_full;
  assign bus.ser_dout       = sreg[W-1];
  assign bus.ser_dout_valid = (state != IDLE);
`ifdef PAR2SER_PARITY_EN
  assign bus.ser_dout_last  = (state == PARITY);
`else
  assign bus.ser_dout_last  = (state == SHIFT) && (cnt == CNT_LAST);
`endif

endmodule

`default_nettype wire

// File: tb/tb_par2ser.sv
// +----------------------------------------------------------------------------+
// | tb_par2ser : directed self-checking bench for par2ser (W = 8)              |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_par2ser;

  localparam int W = 8;

  logic clk;
  logic rst;
  int   n_total = 0;
  int   n_bad   = 0;

  par2ser_if #(.W(W)) bus ();

  par2ser #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-cycle traces, newest sample in bit 0, oldest (cycle 0) highest.
  logic [7:0]  wq[4];
  int          ws[4];
  int          wn;
  logic [63:0] v_valid, v_dout, v_last, v_ready, v_acc;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers wq[i] from cycle ws[i] until accepted; records outputs each cycle.
  task automatic run_seq(input int ncyc);
    int   idx;
    logic acc;
    idx     = 0;
    v_valid = '0; v_dout = '0; v_last = '0; v_ready = '0; v_acc = '0;
    for (int c = 0; c < ncyc; c++) begin
      if (idx < wn && c >= ws[idx]) begin
        bus.par_din       = wq[idx];
        bus.par_din_valid = 1'b1;
      end else begin
        bus.par_din       = '0;
        bus.par_din_valid = 1'b0;
      end
      acc     = bus.par_din_valid && bus.par_din_ready;
      v_valid = {v_valid[62:0], bus.ser_dout_valid};
      v_dout  = {v_dout[62:0], bus.ser_dout & bus.ser_dout_valid};
      v_last  = {v_last[62:0], bus.ser_dout_last};
      v_ready = {v_ready[62:0], bus.par_din_ready};
      v_acc   = {v_acc[62:0], acc};
      tick();
      if (acc) idx++;
    end
    bus.par_din_valid = 1'b0;
  endtask

  logic [7:0]  expq[$];
  logic [7:0]  cur, got_w;
  logic [8:0]  sh;
  int          sent, rcvd;
  logic        any_v, acc1;

  initial begin
    rst               = 1'b1;
    bus.par_din       = '0;
    bus.par_din_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("reset_valid", bus.ser_dout_valid, 1'b0);
    chk("reset_last",  bus.ser_dout_last,  1'b0);
    chk("reset_dout",  bus.ser_dout,       1'b0);
    chk("reset_ready", bus.par_din_ready,  1'b1);

`ifndef PAR2SER_PARITY_EN
    // single word
    wq[0] = 8'hA5; ws[0] = 0; wn = 1;
    run_seq(10);
    chk("single_valid", v_valid, 64'h1FE);
    chk("single_dout",  v_dout,  {54'd0, 1'b0, 8'hA5, 1'b0});
    chk("single_last",  v_last,  64'h002);
    chk("single_ready", v_ready, 64'h3FF);

    // back-to-back with hold register
    wq[0] = 8'hA5; wq[1] = 8'h3C; wq[2] = 8'hFF;
    ws[0] = 0; ws[1] = 0; ws[2] = 0; wn = 3;
    run_seq(26);
    chk("b2b_valid", v_valid, 64'h1FFFFFE);
    chk("b2b_dout",  v_dout,  {38'd0, 1'b0, 24'hA53CFF, 1'b0});
    chk("b2b_last",  v_last,  64'h20202);
    chk("b2b_ready", v_ready, 64'h30101FF);

    // backpressure: third word waits until second leaves the hold register
    wq[0] = 8'h12; wq[1] = 8'h34; wq[2] = 8'h56; wn = 3;
    run_seq(26);
    chk("bp_accept", v_acc,  64'h3010000);
    chk("bp_dout",   v_dout, {38'd0, 1'b0, 24'h123456, 1'b0});
    chk("bp_ready",  v_ready, 64'h30101FF);

    // word offered exactly on the last-bit cycle loads directly, no gap
    wq[0] = 8'hA5; wq[1] = 8'h3C; ws[0] = 0; ws[1] = 8; wn = 2;
    run_seq(18);
    chk("direct_accept", v_acc,   64'h20200);
    chk("direct_valid",  v_valid, 64'h1FFFE);
    chk("direct_dout",   v_dout,  {46'd0, 1'b0, 16'hA53C, 1'b0});
    chk("direct_last",   v_last,  64'h202);
`else
    wq[0] = 8'hA5; ws[0] = 0; wn = 1;
    run_seq(11);
    chk("par_a5_valid", v_valid, 64'h3FE);
    chk("par_a5_dout",  v_dout,  {53'd0, 1'b0, 8'hA5, 1'b0, 1'b0});
    chk("par_a5_last",  v_last,  64'h002);

    wq[0] = 8'h07; ws[0] = 0; wn = 1;
    run_seq(11);
    chk("par_07_dout",  v_dout,  {53'd0, 1'b0, 8'h07, 1'b1, 1'b0});
    chk("par_07_last",  v_last,  64'h002);

    wq[0] = 8'hA5; wq[1] = 8'h07; ws[0] = 0; ws[1] = 0; wn = 2;
    run_seq(20);
    chk("par_b2b_valid", v_valid, 64'h7FFFE);
    chk("par_b2b_dout",  v_dout,  {44'd0, 1'b0, 8'hA5, 1'b0, 8'h07, 1'b1, 1'b0});
    chk("par_b2b_last",  v_last,  64'h402);
`endif

    // reset mid-frame with a word also waiting in the hold register
    bus.par_din = 8'hC3; bus.par_din_valid = 1'b1;
    tick();
    bus.par_din = 8'h55;
    chk("rstmid_bit0", bus.ser_dout, 1'b1);
    tick();
    bus.par_din_valid = 1'b0;
    chk("rstmid_held_ready", bus.par_din_ready, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid_valid", bus.ser_dout_valid, 1'b0);
    chk("rstmid_ready", bus.par_din_ready,  1'b1);
    chk("rstmid_last",  bus.ser_dout_last,  1'b0);
    any_v = 1'b0;
    for (int i = 0; i < 12; i++) begin
      any_v = any_v | bus.ser_dout_valid;
      tick();
    end
    chk("rstmid_residue", any_v, 1'b0);

    wq[0] = 8'h81; ws[0] = 0; wn = 1;
`ifndef PAR2SER_PARITY_EN
    run_seq(10);
    chk("after_rst_valid", v_valid, 64'h1FE);
    chk("after_rst_dout",  v_dout,  {54'd0, 1'b0, 8'h81, 1'b0});
    chk("after_rst_last",  v_last,  64'h002);
`else
    run_seq(11);
    chk("after_rst_valid", v_valid, 64'h3FE);
    chk("after_rst_dout",  v_dout,  {53'd0, 1'b0, 8'h81, 1'b0, 1'b0});
    chk("after_rst_last",  v_last,  64'h002);
`endif

    // loopback: deserialise 256 random words from the lane
    sent = 0; rcvd = 0; sh = '0;
    cur  = 8'($urandom);
    for (int c = 0; c < 8000 && rcvd < 256; c++) begin
      bus.par_din       = cur;
      bus.par_din_valid = (sent < 256) && ($urandom_range(0, 3) != 0);
      acc1 = bus.par_din_valid && bus.par_din_ready;
      if (bus.ser_dout_valid) begin
        sh = {sh[7:0], bus.ser_dout};
        if (bus.ser_dout_last) begin
`ifdef PAR2SER_PARITY_EN
          got_w = sh[8:1];
          chk("lb_parity", sh[0], ^got_w);
`else
          got_w = sh[7:0];
`endif
          if (expq.size() == 0) chk("lb_extra_frame", 1'b1, 1'b0);
          else chk("lb_word", got_w, expq.pop_front());
          rcvd++;
        end
      end
      tick();
      if (acc1) begin
        expq.push_back(cur);
        sent++;
        cur = 8'($urandom);
      end
    end
    bus.par_din_valid = 1'b0;
    chk("lb_count", rcvd, 256);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/par2ser.md
# par2ser

Parallel-to-serial transmitter, the sending end of the serial link consumed by `ser2par`.
- Accepts `W`-bit words over a valid/ready handshake and shifts each word out MSB first, one bit per clock, with a per-bit valid strobe.
- A one-word holding register keeps the serial stream gap-free across back-to-back words.
- Sits between a word-oriented producer (FIFO or register bank) and the serial lane.

## Interface
- `W`, default 8: word width in bits; legal range `W >= 2`.
- `clk`, input, 1: clock; all logic is on the rising edge.
- `rst`, input, 1: synchronous reset, active-high.
- `par_din`, input, `W`: parallel word to transmit.
- `par_din_valid`, input, 1: `par_din` is valid.
- `par_din_ready`, output, 1: the block can accept a word this cycle.
- `ser_dout`, output, 1: serial data bit.
- `ser_dout_valid`, output, 1: `ser_dout` carries a valid bit this cycle.
- `ser_dout_last`, output, 1: the current bit is the final bit of its frame.

## Operation
- A word is accepted on a rising edge where `par_din_valid && par_din_ready`.
- `par_din_ready` equals `!hold_full`. It is driven straight from a register, with no combinational path from `par_din_valid`.
- Datapath:
  - shift register `sreg[W-1:0]`
  - bit counter `cnt`, `$clog2(W)` bits, counting `0..W-1`
  - holding register `hold_q` with flag `hold_full`
- FSM states: `IDLE`, `SHIFT`, and `PARITY` (present only with the macro).
- In `IDLE`, an accepted word loads into `sreg`, `cnt` clears to 0, and the state moves to `SHIFT`.
- In `SHIFT`:
  - Each cycle `sreg` shifts left by one and `cnt` increments.
  - When `cnt == W-1` (last bit), the next state is chosen as follows:
    - Parity compiled in: go to `PARITY`.
    - Otherwise, if `hold_full`: move `hold_q` into `sreg`, clear `hold_full` and `cnt`, stay in `SHIFT`.
    - Otherwise, if a word is accepted this same cycle: load it directly into `sreg` and stay in `SHIFT`.
    - Otherwise: go to `IDLE`.
- A word accepted in `SHIFT` or `PARITY` that is not loaded directly into `sreg` is written to `hold_q` and sets `hold_full`.
- Outputs:
  - `ser_dout = sreg[W-1]`.
  - `ser_dout_valid` is 1 in `SHIFT` and `PARITY`, and 0 in `IDLE`.
  - `ser_dout_last` is 1 when (`SHIFT` and `cnt == W-1` with no parity) or in `PARITY`.
- Reset values: state `IDLE`, `sreg = 0`, `cnt = 0`, `hold_full = 0`, `par_din_ready = 1`, `ser_dout = 0`, `ser_dout_valid = 0`, `ser_dout_last = 0`.
- Reset during a frame drops both the in-flight word and the held word. `ser_dout_valid` is low in the cycle after `rst` is sampled. No partial frame resumes after reset.

## Timing
- Latency: a word accepted at edge t drives its MSB on `ser_dout` with `ser_dout_valid = 1` in the cycle after edge t.
- A frame lasts `W` cycles, or `W+1` with parity.
- With `hold_q` filled, or with a word offered on the last-bit cycle, the next frame's MSB follows the previous frame's last bit with zero gap cycles.
- With `par_din_valid` held high continuously, sustained throughput is one word per frame length.
- `par_din_ready` deasserts the cycle after `hold_q` fills and reasserts the cycle after `hold_q` moves to `sreg`.
- Simultaneous load from `hold_q` and accept: not possible, because `ready = 0` while `hold_full = 1`.
- Counter wrap: `cnt` never exceeds `W-1`. For non-power-of-2 `W`, the compare is exact and the counter never wraps naturally.

## Configuration
- Macro `PAR2SER_PARITY_EN`.
- Defined:
  - After bit 0 the FSM enters `PARITY` for one cycle and drives the even-parity bit, `^word`.
  - `ser_dout_last` marks the parity bit, not bit 0.
  - The load-from-hold and direct-accept decisions happen on the `PARITY` cycle.
- Undefined: no `PARITY` state, frames are exactly `W` bits, and the output is bit-compatible with `ser2par`.

## Structure
- Package `ser_link_pkg` contains:
  - the FSM state enum `p2s_state_e` (`IDLE`, `SHIFT`, `PARITY`)
  - the `localparam` function for counter width, shared with `ser2par`
- There are no sub-modules; this is a single flat module. The holding register is too small to justify splitting out.

## Test plan
All scenarios use `W = 8`.
- **Single word:** after reset, send `0xA5`. Expect `ser_dout` = 1,0,1,0,0,1,0,1 over 8 consecutive valid cycles, starting one cycle after acceptance, with `last` only on the 8th. Then expect `valid = 0`.
- **Back-to-back:** stream `0xA5`, `0x3C`, `0xFF` with valid held high. Expect 24 contiguous valid bits, `last` at bit cycles 8, 16 and 24, and `ready` low while `hold_q` is full.
- **Backpressure:** offer a 3rd word while the 1st is shifting and the 2nd is held. Expect `ready = 0`; the word is not accepted until the cycle after the 2nd moves to `sreg`, and it is transmitted intact.
- **Reset mid-frame:** assert `rst` after 3 bits of `0xC3`. Expect `valid` low the next cycle, `ready = 1`, and no residual bits. A following `0x81` transmits cleanly.
- **Loopback:** connect `ser_dout`/`ser_dout_valid` to `ser2par` and send 256 random words. Expect `par_dout` to equal each sent word, asserted once per frame.
- **`PAR2SER_PARITY_EN`:** with the macro defined, `0xA5` yields 8 data bits and then parity 0. `0x07` yields parity 1. `last` is asserted only on the parity bit, and frames are 9 cycles.
